// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control path: control-word bit positions,
// single-bit control masks, opcode encoding and the fixed fetch words.
package cpu_ctrl_pkg;

    // Control word bit positions.
    localparam int unsigned BitHlt = 15;
    localparam int unsigned BitMi  = 14;
    localparam int unsigned BitRi  = 13;
    localparam int unsigned BitRo  = 12;
    localparam int unsigned BitIo  = 11;
    localparam int unsigned BitIi  = 10;
    localparam int unsigned BitAi  = 9;
    localparam int unsigned BitAo  = 8;
    localparam int unsigned BitEo  = 7;
    localparam int unsigned BitSu  = 6;
    localparam int unsigned BitBi  = 5;
    localparam int unsigned BitOi  = 4;
    localparam int unsigned BitCe  = 3;
    localparam int unsigned BitCo  = 2;
    localparam int unsigned BitJ   = 1;
    localparam int unsigned BitFi  = 0;

    localparam int unsigned CtrlW = 16;

    // One-hot masks for building control words.
    localparam logic [CtrlW-1:0] CwNone = 16'h0000;
    localparam logic [CtrlW-1:0] CwHlt  = 16'h0001 << BitHlt;
    localparam logic [CtrlW-1:0] CwMi   = 16'h0001 << BitMi;
    localparam logic [CtrlW-1:0] CwRi   = 16'h0001 << BitRi;
    localparam logic [CtrlW-1:0] CwRo   = 16'h0001 << BitRo;
    localparam logic [CtrlW-1:0] CwIo   = 16'h0001 << BitIo;
    localparam logic [CtrlW-1:0] CwIi   = 16'h0001 << BitIi;
    localparam logic [CtrlW-1:0] CwAi   = 16'h0001 << BitAi;
    localparam logic [CtrlW-1:0] CwAo   = 16'h0001 << BitAo;
    localparam logic [CtrlW-1:0] CwEo   = 16'h0001 << BitEo;
    localparam logic [CtrlW-1:0] CwSu   = 16'h0001 << BitSu;
    localparam logic [CtrlW-1:0] CwBi   = 16'h0001 << BitBi;
    localparam logic [CtrlW-1:0] CwOi   = 16'h0001 << BitOi;
    localparam logic [CtrlW-1:0] CwCe   = 16'h0001 << BitCe;
    localparam logic [CtrlW-1:0] CwCo   = 16'h0001 << BitCo;
    localparam logic [CtrlW-1:0] CwJ    = 16'h0001 << BitJ;
    localparam logic [CtrlW-1:0] CwFi   = 16'h0001 << BitFi;

    // Fetch words shared by every opcode.
    localparam logic [CtrlW-1:0] CwFetch0 = CwCo | CwMi;
    localparam logic [CtrlW-1:0] CwFetch1 = CwRo | CwIi | CwCe;

    // Opcodes 1001..1101 are unassigned and decode as NOP.
    typedef enum logic [3:0] {
        OpNop = 4'h0,
        OpLda = 4'h1,
        OpAdd = 4'h2,
        OpSub = 4'h3,
        OpSta = 4'h4,
        OpLdi = 4'h5,
        OpJmp = 4'h6,
        OpJc  = 4'h7,
        OpJz  = 4'h8,
        OpOut = 4'hE,
        OpHlt = 4'hF
    } opcode_e;

endpackage

// File: rtl/control_rom.sv
// Combinational microcode ROM: (opcode, microstep, flags) -> control word.
// Also flags the last non-empty step of the instruction so the sequencer can
// end it early when EARLY_STEP_RESET_EN is defined in the top.
module control_rom
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 4
) (
    input  logic [OPCODE_W-1:0] i_instr,
    input  logic [2:0]          i_step,
    input  logic                i_carry,
    input  logic                i_zero,
    output logic [CtrlW-1:0]    o_ctrl,
    output logic                o_last_step
);

    opcode_e    w_op;
    logic [2:0] w_last_idx;

    assign w_op = opcode_e'(i_instr[3:0]);

    // Control word decode; steps 5..7 and unused slots stay empty.
    always_comb begin
        o_ctrl = CwNone;
        case (i_step)
            3'd0: o_ctrl = CwFetch0;
            3'd1: o_ctrl = CwFetch1;
            3'd2: begin
                case (w_op)
                    OpLda, OpAdd, OpSub, OpSta: o_ctrl = CwIo | CwMi;
                    OpLdi:                      o_ctrl = CwIo | CwAi;
                    OpJmp:                      o_ctrl = CwIo | CwJ;
                    OpJc:                       o_ctrl = i_carry ? (CwIo | CwJ) : CwNone;
                    OpJz:                       o_ctrl = i_zero ? (CwIo | CwJ) : CwNone;
                    OpOut:                      o_ctrl = CwAo | CwOi;
                    OpHlt:                      o_ctrl = CwHlt;
                    default:                    o_ctrl = CwNone;
                endcase
            end
            3'd3: begin
                case (w_op)
                    OpLda:        o_ctrl = CwRo | CwAi;
                    OpAdd, OpSub: o_ctrl = CwRo | CwBi;
                    OpSta:        o_ctrl = CwAo | CwRi;
                    default:      o_ctrl = CwNone;
                endcase
            end
            3'd4: begin
                case (w_op)
                    OpAdd:   o_ctrl = CwEo | CwAi | CwFi;
                    OpSub:   o_ctrl = CwEo | CwAi | CwSu | CwFi;
                    default: o_ctrl = CwNone;
                endcase
            end
            default: o_ctrl = CwNone;
        endcase
    end

    // Index of the last non-empty step; fetch (T1) is the minimum.
    always_comb begin
        w_last_idx = 3'd1;
        case (w_op)
            OpLda, OpSta:                 w_last_idx = 3'd3;
            OpAdd, OpSub:                 w_last_idx = 3'd4;
            OpLdi, OpJmp, OpOut, OpHlt:   w_last_idx = 3'd2;
            OpJc:                         w_last_idx = i_carry ? 3'd2 : 3'd1;
            OpJz:                         w_last_idx = i_zero ? 3'd2 : 3'd1;
            default:                      w_last_idx = 3'd1;
        endcase
    end

    assign o_last_step = (i_step >= w_last_idx);

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer for the 8-bit CPU. Holds the microstep counter
// and sticky halt flag, and gates the ROM control word with reset and halt.
// Optional feature macro: EARLY_STEP_RESET_EN -- when defined, each
// instruction ends after its last non-empty microstep instead of running all
// STEPS steps.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned STEPS    = 5,
    parameter int unsigned OPCODE_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] instr,
    input  logic                carry,
    input  logic                zero,
    output logic [CtrlW-1:0]    ctrl,
    output logic [2:0]          step,
    output logic                halted
);

    localparam logic [2:0] LastStep = 3'(STEPS - 1);

`ifdef EARLY_STEP_RESET_EN
    localparam bit EarlyEn = 1'b1;
`else
    localparam bit EarlyEn = 1'b0;
`endif

    logic [2:0]       r_step;
    logic             r_halted;
    logic [2:0]       w_step_next;
    logic             w_halted_next;
    logic [CtrlW-1:0] w_rom_ctrl;
    logic             w_last_step;
    logic             w_halt_req;
    logic             w_wrap;

    control_rom #(
        .OPCODE_W (OPCODE_W)
    ) u_rom (
        .i_instr     (instr),
        .i_step      (r_step),
        .i_carry     (carry),
        .i_zero      (zero),
        .o_ctrl      (w_rom_ctrl),
        .o_last_step (w_last_step)
    );

    // The HLT bit only appears at T2 of the HLT opcode.
    assign w_halt_req = w_rom_ctrl[BitHlt];
    assign w_wrap     = (r_step == LastStep) || (EarlyEn && w_last_step);

    // Next-state: halt freezes the counter, otherwise advance or wrap.
    always_comb begin
        w_step_next   = r_step;
        w_halted_next = r_halted;
        if (r_halted) begin
            w_step_next = r_step;
        end else if (w_halt_req) begin
            w_halted_next = 1'b1;
            w_step_next   = r_step;
        end else if (w_wrap) begin
            w_step_next = 3'd0;
        end else begin
            w_step_next = r_step + 3'd1;
        end
    end

    // Step counter and sticky halt register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_step   <= 3'd0;
            r_halted <= 1'b0;
        end else begin
            r_step   <= w_step_next;
            r_halted <= w_halted_next;
        end
    end

    // Output gating: reset forces zero without waiting for a clock.
    always_comb begin
        ctrl = w_rom_ctrl;
        if (rst) begin
            ctrl = CwNone;
        end else if (r_halted) begin
            ctrl = CwHlt;
        end
    end

    assign step   = r_step;
    assign halted = r_halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer. Each step pushes its stimulus and the
// expected outputs to a scoreboard queue; the queue is drained one clock per
// entry, comparing outputs #1 after inputs settle, before the next edge.
module tb_control_sequencer;

    logic        clk;
    logic        rst;
    logic        rst8;
    logic [3:0]  instr;
    logic [3:0]  instr8;
    logic        carry;
    logic        zero;
    logic [15:0] ctrl;
    logic [15:0] ctrl8;
    logic [2:0]  step;
    logic [2:0]  step8;
    logic        halted;
    logic        halted8;

    int total;
    int bad;

    typedef struct {
        logic        sel;
        logic [3:0]  instr;
        logic        carry;
        logic        zero;
        logic [2:0]  step;
        logic [15:0] ctrl;
        logic        halted;
    } item_t;

    item_t sb[$];

    control_sequencer #(
        .STEPS    (5),
        .OPCODE_W (4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .instr  (instr),
        .carry  (carry),
        .zero   (zero),
        .ctrl   (ctrl),
        .step   (step),
        .halted (halted)
    );

    control_sequencer #(
        .STEPS    (8),
        .OPCODE_W (4)
    ) dut8 (
        .clk    (clk),
        .rst    (rst8),
        .instr  (instr8),
        .carry  (carry),
        .zero   (zero),
        .ctrl   (ctrl8),
        .step   (step8),
        .halted (halted8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic sel, input logic [3:0] i, input logic c, input logic z,
                        input logic [2:0] s, input logic [15:0] w, input logic h);
        item_t it;
        it.sel = sel; it.instr = i; it.carry = c; it.zero = z;
        it.step = s; it.ctrl = w; it.halted = h;
        sb.push_back(it);
    endtask

    task automatic cmp(input string tag, input item_t it);
        logic [15:0] oc;
        logic [2:0]  os;
        logic        oh;
        oc = it.sel ? ctrl8 : ctrl;
        os = it.sel ? step8 : step;
        oh = it.sel ? halted8 : halted;
        total++;
        assert (oc === it.ctrl) else begin
            bad++;
            $error("FAIL %s ctrl got=%h exp=%h", tag, oc, it.ctrl);
        end
        total++;
        assert (os === it.step) else begin
            bad++;
            $error("FAIL %s step got=%0d exp=%0d", tag, os, it.step);
        end
        total++;
        assert (oh === it.halted) else begin
            bad++;
            $error("FAIL %s halted got=%0b exp=%0b", tag, oh, it.halted);
        end
    endtask

    // Apply the head entry's inputs, compare, no clock.
    task automatic check_one(input string tag);
        item_t it;
        it = sb.pop_front();
        if (it.sel) instr8 = it.instr; else instr = it.instr;
        carry = it.carry;
        zero  = it.zero;
        #1;
        cmp(tag, it);
    endtask

    // One clock per entry: apply, compare, then advance past the edge.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sb.size() > 0) begin
            check_one($sformatf("%s[%0d]", tag, n));
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        rst    = 1'b1;
        rst8   = 1'b1;
        instr  = 4'h1;
        instr8 = 4'h1;
        carry  = 1'b0;
        zero   = 1'b0;

        // Reset state: outputs quiet while rst high, even across an edge.
        push(0, 4'h1, 0, 0, 3'd0, 16'h0000, 0);
        check_one("rst_hold");
        @(posedge clk);
        #1;
        push(0, 4'h1, 0, 0, 3'd0, 16'h0000, 0);
        check_one("rst_edge");
        rst = 1'b0;

`ifndef EARLY_STEP_RESET_EN
        // LDA over all five steps, then wrap back to T0.
        push(0, 4'h1, 0, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h1, 0, 0, 3'd1, 16'h1408, 0);
        push(0, 4'h1, 0, 0, 3'd2, 16'h4800, 0);
        push(0, 4'h1, 0, 0, 3'd3, 16'h1200, 0);
        push(0, 4'h1, 0, 0, 3'd4, 16'h0000, 0);
        drain("lda");

        // SUB then ADD.
        push(0, 4'h3, 0, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h3, 0, 0, 3'd1, 16'h1408, 0);
        push(0, 4'h3, 0, 0, 3'd2, 16'h4800, 0);
        push(0, 4'h3, 0, 0, 3'd3, 16'h1020, 0);
        push(0, 4'h3, 0, 0, 3'd4, 16'h02C1, 0);
        push(0, 4'h2, 0, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h2, 0, 0, 3'd1, 16'h1408, 0);
        push(0, 4'h2, 0, 0, 3'd2, 16'h4800, 0);
        push(0, 4'h2, 0, 0, 3'd3, 16'h1020, 0);
        push(0, 4'h2, 0, 0, 3'd4, 16'h0281, 0);
        drain("addsub");

        // JC untaken/taken with carry toggling outside T2; JZ taken/untaken.
        push(0, 4'h7, 1, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h7, 1, 0, 3'd1, 16'h1408, 0);
        push(0, 4'h7, 0, 0, 3'd2, 16'h0000, 0);
        push(0, 4'h7, 1, 0, 3'd3, 16'h0000, 0);
        push(0, 4'h7, 1, 1, 3'd4, 16'h0000, 0);
        push(0, 4'h7, 0, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h7, 0, 0, 3'd1, 16'h1408, 0);
        push(0, 4'h7, 1, 0, 3'd2, 16'h0802, 0);
        push(0, 4'h7, 0, 1, 3'd3, 16'h0000, 0);
        push(0, 4'h7, 0, 0, 3'd4, 16'h0000, 0);
        push(0, 4'h8, 0, 1, 3'd0, 16'h4004, 0);
        push(0, 4'h8, 0, 1, 3'd1, 16'h1408, 0);
        push(0, 4'h8, 0, 1, 3'd2, 16'h0802, 0);
        push(0, 4'h8, 1, 0, 3'd3, 16'h0000, 0);
        push(0, 4'h8, 1, 1, 3'd4, 16'h0000, 0);
        push(0, 4'h8, 1, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h8, 1, 0, 3'd1, 16'h1408, 0);
        push(0, 4'h8, 1, 0, 3'd2, 16'h0000, 0);
        push(0, 4'h8, 0, 1, 3'd3, 16'h0000, 0);
        push(0, 4'h8, 0, 0, 3'd4, 16'h0000, 0);
        drain("jcjz");
`else
        // Early termination: LDI, NOP, undefined, untaken/taken JC, ADD.
        push(0, 4'h5, 0, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h5, 0, 0, 3'd1, 16'h1408, 0);
        push(0, 4'h5, 0, 0, 3'd2, 16'h0A00, 0);
        push(0, 4'h0, 0, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h0, 0, 0, 3'd1, 16'h1408, 0);
        push(0, 4'hA, 1, 1, 3'd0, 16'h4004, 0);
        push(0, 4'hA, 1, 1, 3'd1, 16'h1408, 0);
        push(0, 4'h7, 0, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h7, 0, 0, 3'd1, 16'h1408, 0);
        push(0, 4'h7, 1, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h7, 1, 0, 3'd1, 16'h1408, 0);
        push(0, 4'h7, 1, 0, 3'd2, 16'h0802, 0);
        push(0, 4'h2, 0, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h2, 0, 0, 3'd1, 16'h1408, 0);
        push(0, 4'h2, 0, 0, 3'd2, 16'h4800, 0);
        push(0, 4'h2, 0, 0, 3'd3, 16'h1020, 0);
        push(0, 4'h2, 0, 0, 3'd4, 16'h0281, 0);
        drain("early");
`endif

        // HLT: emits 0x8000 at T2, then frozen at step 2 regardless of inputs.
        push(0, 4'hF, 0, 0, 3'd0, 16'h4004, 0);
        push(0, 4'hF, 0, 0, 3'd1, 16'h1408, 0);
        push(0, 4'hF, 0, 0, 3'd2, 16'h8000, 0);
        for (int i = 0; i < 10; i++) begin
            push(0, (i % 3 == 0) ? 4'h1 : ((i % 3 == 1) ? 4'h7 : 4'hF),
                 1'(i), 1'(i >> 1), 3'd2, 16'h8000, 1);
        end
        drain("halt");

        // Async reset mid-cycle clears step/halted before any edge.
        rst = 1'b1;
        push(0, 4'h1, 1, 1, 3'd0, 16'h0000, 0);
        check_one("async_rst");
        rst = 1'b0;
        push(0, 4'h1, 0, 0, 3'd0, 16'h4004, 0);
        push(0, 4'h1, 0, 0, 3'd1, 16'h1408, 0);
        drain("post_rst");

`ifndef EARLY_STEP_RESET_EN
        // Eight-step instance: LDA runs 0..7, steps 5..7 empty, then wraps.
        rst8 = 1'b0;
        push(1, 4'h1, 0, 0, 3'd0, 16'h4004, 0);
        push(1, 4'h1, 0, 0, 3'd1, 16'h1408, 0);
        push(1, 4'h1, 0, 0, 3'd2, 16'h4800, 0);
        push(1, 4'h1, 0, 0, 3'd3, 16'h1200, 0);
        push(1, 4'h1, 0, 0, 3'd4, 16'h0000, 0);
        push(1, 4'h1, 0, 0, 3'd5, 16'h0000, 0);
        push(1, 4'h1, 0, 0, 3'd6, 16'h0000, 0);
        push(1, 4'h1, 0, 0, 3'd7, 16'h0000, 0);
        push(1, 4'h1, 0, 0, 3'd0, 16'h4004, 0);
        drain("steps8");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
